// File: rtl/cakegame_uc_pkg.sv
// Shared constants for the cake game control unit: state codes and
// output-mux select values. The top level and the bench use the state
// codes to decode db_estado.
package cakegame_uc_pkg;

  localparam int ESTADO_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL   = 4'h0,
    PREPARA   = 4'h1,
    MOSTRA    = 4'h2,
    ZERA_SHOW = 4'h3,
    ESPERA    = 4'h4,
    REGISTRA  = 4'h5,
    COMPARA   = 4'h6,
    ACERTO    = 4'h7,
    PROXIMO   = 4'h8,
    ULTIMO    = 4'h9,
    GANHOU    = 4'hA,
    PERDEU    = 4'hB
  } estado_t;

  localparam logic [1:0] SEL_BLANK = 2'd0;
  localparam logic [1:0] SEL_MEM   = 2'd1;
  localparam logic [1:0] SEL_BTN   = 2'd2;

endpackage

// File: rtl/cakegame_uc_if.sv
// Control/status bundle between the control unit and the cake game
// datapath. The control unit (master) drives every clear/enable/select
// and reads the datapath status flags; the datapath (slave) is the
// mirror image. Moore semantics: controls are held for the whole state,
// has_play is a one-cycle pulse, the remaining flags are levels.
interface cakegame_uc_if;
  logic [1:0] out_sel;
  logic       clear_reg;
  logic       enable_reg;
  logic       clear_mem_counter;
  logic       enable_mem_counter;
  logic       clear_show_counter;
  logic       enable_show_counter;
  logic       enable_timeout_counter;
  logic       clear_points_counter;
  logic       enable_points_counter;
  logic       end_mem_counter;
  logic       correct_play;
  logic       has_play;
  logic       end_show;
  logic       half_show;
  logic       timeout;

  modport master (
    output out_sel, clear_reg, enable_reg,
           clear_mem_counter, enable_mem_counter,
           clear_show_counter, enable_show_counter,
           enable_timeout_counter,
           clear_points_counter, enable_points_counter,
    input  end_mem_counter, correct_play, has_play,
           end_show, half_show, timeout
  );

  modport slave (
    input  out_sel, clear_reg, enable_reg,
           clear_mem_counter, enable_mem_counter,
           clear_show_counter, enable_show_counter,
           enable_timeout_counter,
           clear_points_counter, enable_points_counter,
    output end_mem_counter, correct_play, has_play,
           end_show, half_show, timeout
  );
endinterface

// File: rtl/cakegame_uc.sv
// Moore control unit for the cake game. Sequences each round (show item,
// wait for play, register, compare, score) and reports game status.
// Outputs decode from the state register only.
import cakegame_uc_pkg::*;

module cakegame_uc (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                dificuldade,
  cakegame_uc_if.master       dp,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic [ESTADO_W-1:0] db_estado
);

  logic [ESTADO_W-1:0] r_estado;
  logic [ESTADO_W-1:0] w_next;
  logic                w_show_done;
  logic [1:0]          w_out_sel;
  logic                w_clear_reg, w_enable_reg;
  logic                w_clear_mem, w_enable_mem;
  logic                w_clear_show, w_enable_show;
  logic                w_enable_timeout;
  logic                w_clear_points, w_enable_points;
  logic                w_pronto, w_ganhou, w_perdeu;

  // Difficulty picks which show-timer flag ends the display phase.
  assign w_show_done = dificuldade ? dp.half_show : dp.end_show;

  // State register; reset returns to INICIAL without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= INICIAL;
    else       r_estado <= w_next;
  end

  // Next-state logic; unused codes fall back to INICIAL.
  always_comb begin
    w_next = INICIAL;
    case (r_estado)
      INICIAL:   w_next = iniciar ? PREPARA : INICIAL;
      PREPARA:   w_next = MOSTRA;
      MOSTRA:    w_next = w_show_done ? ZERA_SHOW : MOSTRA;
      ZERA_SHOW: w_next = ESPERA;
      ESPERA: begin
        // A play arriving together with the timeout still counts.
        if (dp.has_play)     w_next = REGISTRA;
        else if (dp.timeout) w_next = PERDEU;
        else                 w_next = ESPERA;
      end
      REGISTRA:  w_next = COMPARA;
      COMPARA: begin
        if (!dp.correct_play)        w_next = PERDEU;
        else if (dp.end_mem_counter) w_next = ULTIMO;
        else                         w_next = ACERTO;
      end
      ACERTO:    w_next = PROXIMO;
      // PROXIMO also covers the sync ROM latency after the address bump.
      PROXIMO:   w_next = MOSTRA;
      ULTIMO:    w_next = GANHOU;
      GANHOU:    w_next = iniciar ? PREPARA : GANHOU;
      PERDEU:    w_next = iniciar ? PREPARA : PERDEU;
      default:   w_next = INICIAL;
    endcase
  end

  // Moore output decode; anything not named for a state stays low.
  always_comb begin
    w_out_sel        = SEL_BLANK;
    w_clear_reg      = 1'b0;
    w_enable_reg     = 1'b0;
    w_clear_mem      = 1'b0;
    w_enable_mem     = 1'b0;
    w_clear_show     = 1'b0;
    w_enable_show    = 1'b0;
    w_enable_timeout = 1'b0;
    w_clear_points   = 1'b0;
    w_enable_points  = 1'b0;
    w_pronto         = 1'b0;
    w_ganhou         = 1'b0;
    w_perdeu         = 1'b0;
    case (r_estado)
      PREPARA: begin
        w_clear_reg    = 1'b1;
        w_clear_mem    = 1'b1;
        w_clear_show   = 1'b1;
        w_clear_points = 1'b1;
      end
      MOSTRA: begin
        w_out_sel     = SEL_MEM;
        w_enable_show = 1'b1;
      end
      ZERA_SHOW: w_clear_show = 1'b1;
      ESPERA: begin
        w_out_sel        = SEL_BTN;
        w_enable_timeout = 1'b1;
      end
      REGISTRA: begin
        w_out_sel    = SEL_BTN;
        w_enable_reg = 1'b1;
      end
      COMPARA: w_out_sel = SEL_BTN;
      ACERTO: begin
        w_enable_points = 1'b1;
        w_enable_mem    = 1'b1;
      end
      PROXIMO: w_clear_reg     = 1'b1;
      ULTIMO:  w_enable_points = 1'b1;
      // Score counter is left alone here so the final score stays visible.
      GANHOU: begin
        w_pronto = 1'b1;
        w_ganhou = 1'b1;
      end
      PERDEU: begin
        w_pronto = 1'b1;
        w_perdeu = 1'b1;
      end
      default: ;
    endcase
  end

  assign dp.out_sel                = w_out_sel;
  assign dp.clear_reg              = w_clear_reg;
  assign dp.enable_reg             = w_enable_reg;
  assign dp.clear_mem_counter      = w_clear_mem;
  assign dp.enable_mem_counter     = w_enable_mem;
  assign dp.clear_show_counter     = w_clear_show;
  assign dp.enable_show_counter    = w_enable_show;
  assign dp.enable_timeout_counter = w_enable_timeout;
  assign dp.clear_points_counter   = w_clear_points;
  assign dp.enable_points_counter  = w_enable_points;
  assign pronto                    = w_pronto;
  assign ganhou                    = w_ganhou;
  assign perdeu                    = w_perdeu;
  assign db_estado                 = r_estado;

endmodule

// File: doc/cakegame_uc.md
Name: cakegame_uc

Overview:
- Moore control unit for the cake game.
- Sits directly upstream of the cake game datapath: drives every clear/enable/select input of the datapath and consumes its status flags (end_mem_counter, correct_play, has_play, end_show, half_show, timeout).
- Sequences each round: show the stored item, wait for the player's play, register it, compare, score, then advance or end the game.
- Exposes game-level status (pronto, ganhou, perdeu) and a debug state code to the top level.

Parameters:
- ESTADO_W, 4, width of the state register and of db_estado. Fixed at 4; values other than 4 are unsupported.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; forces INICIAL immediately.
- iniciar  input  1  start/restart request, level-sampled.
- dificuldade  input  1  0 = full show time (end_show), 1 = half show time (half_show).
- end_mem_counter  input  1  datapath: address counter at last item (15).
- correct_play  input  1  datapath: registered play equals memory item.
- has_play  input  1  datapath: one-cycle play pulse.
- end_show  input  1  datapath: show timer full.
- half_show  input  1  datapath: show timer half.
- timeout  input  1  datapath: play timer expired.
- out_sel  output  2  datapath output mux: 0 = blank, 1 = memory item, 2 = buttons.
- clear_reg  output  1  clears the play register and the edge detector.
- enable_reg  output  1  loads the play register.
- clear_mem_counter, enable_mem_counter  output  1 each  address counter control.
- clear_show_counter, enable_show_counter  output  1 each  show timer control.
- enable_timeout_counter  output  1  runs the play timer; when low, the datapath holds that timer cleared.
- clear_points_counter, enable_points_counter  output  1 each  score counter control.
- pronto  output  1  game finished.
- ganhou  output  1  game won.
- perdeu  output  1  game lost.
- db_estado  output  4  current state code.

Behaviour:
- Moore FSM. Outputs decode from the state register only. Any output not listed for a state is 0.
- Reset: state = INICIAL; all outputs 0; db_estado = 0.
- States (code in hex):
  - INICIAL (0): iniciar -> PREPARA.
  - PREPARA (1): clear_reg, clear_mem_counter, clear_show_counter, clear_points_counter = 1. Next: MOSTRA.
  - MOSTRA (2): out_sel = 1, enable_show_counter = 1. Exit when (dificuldade ? half_show : end_show) -> ZERA_SHOW; otherwise stay.
  - ZERA_SHOW (3): clear_show_counter = 1. Next: ESPERA.
  - ESPERA (4): out_sel = 2, enable_timeout_counter = 1. has_play -> REGISTRA; else timeout -> PERDEU. has_play has priority when both are asserted in the same cycle.
  - REGISTRA (5): out_sel = 2, enable_reg = 1. Next: COMPARA.
  - COMPARA (6): out_sel = 2.
    - !correct_play -> PERDEU.
    - correct_play & end_mem_counter -> ULTIMO.
    - correct_play & !end_mem_counter -> ACERTO.
  - ACERTO (7): enable_points_counter = 1, enable_mem_counter = 1. Next: PROXIMO.
  - PROXIMO (8): clear_reg = 1. Next: MOSTRA. This state also absorbs the one-cycle sync ROM latency after the address increment.
  - ULTIMO (9): enable_points_counter = 1. Next: GANHOU.
  - GANHOU (A): pronto = 1, ganhou = 1, out_sel = 0. iniciar -> PREPARA; else stay.
  - PERDEU (B): pronto = 1, perdeu = 1, out_sel = 0. iniciar -> PREPARA; else stay.
  - Codes C–F are illegal: next state is INICIAL, and all outputs are 0.
- The score counter is never cleared in GANHOU or PERDEU, so the final score stays visible until the next PREPARA.
- iniciar is ignored in every state except INICIAL, GANHOU and PERDEU.
- Inputs other than those named for the current state are ignored. Example: has_play during MOSTRA is dropped; the edge detector is cleared at PROXIMO/PREPARA anyway.
- Reset asserted mid-round: immediate return to INICIAL. Datapath counters are not touched until the next PREPARA.
- Full 16-item win: exactly 16 points increments, 15 address increments.

Decomposition:
- Shared package: state code constants (INICIAL…PERDEU) and out_sel constants (SEL_BLANK = 0, SEL_MEM = 1, SEL_BTN = 2), also used by the top level and the bench to decode db_estado.
- No sub-module. Single file with a state register block, a next-state block and an output-decode block.

Test Plan:
1. Reset while in ESPERA -> state = INICIAL and all outputs 0 within the same cycle, before any clock edge.
2. iniciar, dificuldade = 0, end_show after 1000 cycles -> sequence 1, 2 (1000 cycles), 3, 4, with out_sel = 1 in MOSTRA and out_sel = 2 in ESPERA. Repeat with dificuldade = 1 and half_show -> MOSTRA exits on half_show.
3. In ESPERA: has_play pulse with correct_play = 1 and end_mem_counter = 0 -> 5, 6, 7, 8, 2; enable_points_counter and enable_mem_counter each high for exactly 1 cycle.
4. correct_play = 0 at COMPARA -> PERDEU; pronto = 1 and perdeu = 1 held until iniciar; iniciar -> PREPARA with all four clears high.
5. timeout and has_play asserted in the same cycle in ESPERA -> REGISTRA. timeout alone -> PERDEU.
6. 16 correct plays with end_mem_counter high on the 16th -> ULTIMO then GANHOU; 16 total enable_points_counter pulses; ganhou = 1.
